// File: rtl/rx_pkt_timeout_ctrl.sv
// rx_pkt_timeout_ctrl: per-packet receive supervisor.
// Follows short preamble -> long preamble -> SIG -> data symbols -> FCS and
// requests a fixed-length receiver reset when a stage stalls or the data
// phase overruns its expected symbol count.
module rx_pkt_timeout_ctrl #(
    parameter int TIMER_WIDTH   = 16,
    parameter int SYM_WIDTH     = 15,
    parameter int RST_PULSE_LEN = 4,
    parameter int STAT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sample_in_strobe,
    input  logic                   short_preamble_detected,
    input  logic                   long_preamble_detected,
    input  logic                   pkt_header_valid_strobe,
    input  logic                   pkt_header_valid,
    input  logic                   ht_unsupport,
    input  logic                   phy_len_valid,
    input  logic [SYM_WIDTH-1:0]   n_ofdm_sym,
    input  logic                   ofdm_symbol_eq_out_pulse,
    input  logic                   fcs_out_strobe,
    input  logic [TIMER_WIDTH-1:0] long_timeout,
    input  logic [TIMER_WIDTH-1:0] sig_timeout,
    input  logic [3:0]             sym_margin,
    output logic                   receiver_rst,
    output logic [2:0]             timeout_cause,
    output logic                   pkt_done,
    output logic [STAT_WIDTH-1:0]  timeout_cnt,
    output logic [2:0]             state
);

    localparam int SW1 = SYM_WIDTH + 1;
    localparam int PW  = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
    localparam logic [TIMER_WIDTH-1:0] T_ONE   = TIMER_WIDTH'(1);
    localparam logic [PW-1:0]          P_LAST  = PW'(RST_PULSE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LONG = 3'd1,
        S_WAIT_SIG  = 3'd2,
        S_DATA      = 3'd3,
        S_RST       = 3'd4
    } state_t;

    localparam logic [2:0] C_LONG    = 3'd1;
    localparam logic [2:0] C_SIG     = 3'd2;
    localparam logic [2:0] C_HDR     = 3'd3;
    localparam logic [2:0] C_OVERRUN = 3'd4;
    localparam logic [2:0] C_GAP     = 3'd5;

    state_t                  r_state, w_state_nxt;
    logic [TIMER_WIDTH-1:0]  r_timer, w_timer_nxt;
    logic [SW1-1:0]          r_sym_cnt, r_sym_limit;
    logic [SW1-1:0]          w_sym_cnt_inc, w_sym_limit_eff;
    logic [PW-1:0]           r_pcnt;
    logic [2:0]              r_cause, w_cause_nxt;
    logic                    r_rst, r_done, w_done_nxt;
    logic [STAT_WIDTH-1:0]   r_tcnt;
    logic                    w_enter, w_enter_rst;
    logic                    w_long_exp, w_sig_exp, w_overrun, w_hdr_good;

    // An expiry is the strobe that brings the timer up to the threshold;
    // a zero threshold never expires.
    assign w_long_exp = sample_in_strobe && (long_timeout != '0) &&
                        (r_timer == long_timeout - T_ONE);
    assign w_sig_exp  = sample_in_strobe && (sig_timeout != '0) &&
                        (r_timer == sig_timeout - T_ONE);
    assign w_hdr_good = pkt_header_valid && !ht_unsupport;

    // A length arriving with a symbol is already in force for that symbol.
    assign w_sym_limit_eff = phy_len_valid
                           ? (SW1'(n_ofdm_sym) + SW1'(sym_margin))
                           : r_sym_limit;
    assign w_sym_cnt_inc   = (ofdm_symbol_eq_out_pulse && (r_sym_cnt != '1))
                           ? r_sym_cnt + SW1'(1) : r_sym_cnt;
    assign w_overrun       = ofdm_symbol_eq_out_pulse &&
                             (w_sym_cnt_inc > w_sym_limit_eff);

    // Next-state, reset cause and completion pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && short_preamble_detected) w_state_nxt = S_WAIT_LONG;
            end
            S_WAIT_LONG: begin
                if (!enable)                     w_state_nxt = S_IDLE;
                else if (long_preamble_detected) w_state_nxt = S_WAIT_SIG;
                else if (w_long_exp) begin
                    w_state_nxt = S_RST;
                    w_cause_nxt = C_LONG;
                end
            end
            S_WAIT_SIG: begin
                if (!enable) w_state_nxt = S_IDLE;
                else if (pkt_header_valid_strobe) begin
                    if (w_hdr_good) w_state_nxt = S_DATA;
                    else begin
                        w_state_nxt = S_RST;
                        w_cause_nxt = C_HDR;
                    end
                end else if (w_sig_exp) begin
                    w_state_nxt = S_RST;
                    w_cause_nxt = C_SIG;
                end
            end
            S_DATA: begin
                if (!enable) w_state_nxt = S_IDLE;
                else if (fcs_out_strobe) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_overrun) begin
                    w_state_nxt = S_RST;
                    w_cause_nxt = C_OVERRUN;
                end else if (w_sig_exp && !ofdm_symbol_eq_out_pulse) begin
                    w_state_nxt = S_RST;
                    w_cause_nxt = C_GAP;
                end
            end
            S_RST: begin
                if (r_pcnt == P_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter     = (w_state_nxt != r_state);
    assign w_enter_rst = w_enter && (w_state_nxt == S_RST);

    // Stall timer: cleared on entry and per data symbol, saturating count of strobes.
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_enter || r_state == S_IDLE || r_state == S_RST)
            w_timer_nxt = '0;
        else if (r_state == S_DATA && ofdm_symbol_eq_out_pulse)
            w_timer_nxt = '0;
        else if (sample_in_strobe && r_timer != '1)
            w_timer_nxt = r_timer + T_ONE;
    end

    // State, timers, symbol tracking and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_sym_cnt   <= '0;
            r_sym_limit <= '1;
            r_pcnt      <= '0;
            r_cause     <= '0;
            r_rst       <= 1'b0;
            r_done      <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_rst   <= (w_state_nxt == S_RST);
            r_done  <= w_done_nxt;
            if (w_enter_rst) begin
                r_cause <= w_cause_nxt;
                if (r_tcnt != '1) r_tcnt <= r_tcnt + STAT_WIDTH'(1);
            end
            if (w_enter)               r_pcnt <= '0;
            else if (r_state == S_RST) r_pcnt <= r_pcnt + PW'(1);
            if (w_enter && w_state_nxt == S_DATA) begin
                r_sym_cnt   <= '0;
                r_sym_limit <= '1;
            end else if (r_state == S_DATA) begin
                r_sym_cnt   <= w_sym_cnt_inc;
                r_sym_limit <= w_sym_limit_eff;
            end
        end
    end

    assign receiver_rst  = r_rst;
    assign timeout_cause = r_cause;
    assign pkt_done      = r_done;
    assign timeout_cnt   = r_tcnt;
    assign state         = r_state;

endmodule

// File: tb/tb_rx_pkt_timeout_ctrl.sv
// Directed bench for rx_pkt_timeout_ctrl. A second instance with a 3-bit
// event counter shares all inputs to reach counter saturation quickly.
module tb_rx_pkt_timeout_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_in_strobe;
    logic        short_preamble_detected;
    logic        long_preamble_detected;
    logic        pkt_header_valid_strobe;
    logic        pkt_header_valid;
    logic        ht_unsupport;
    logic        phy_len_valid;
    logic [14:0] n_ofdm_sym;
    logic        ofdm_symbol_eq_out_pulse;
    logic        fcs_out_strobe;
    logic [15:0] long_timeout;
    logic [15:0] sig_timeout;
    logic [3:0]  sym_margin;
    logic        receiver_rst;
    logic [2:0]  timeout_cause;
    logic        pkt_done;
    logic [15:0] timeout_cnt;
    logic [2:0]  state;

    logic        s_rst, s_done;
    logic [2:0]  s_cause, s_state;
    logic [2:0]  s_cnt;

    int checks   = 0;
    int failures = 0;
    int rst_seen = 0;

    always #5 clock = ~clock;

    rx_pkt_timeout_ctrl u_dut (
        .clock(clock), .reset(reset), .enable(enable),
        .sample_in_strobe(sample_in_strobe),
        .short_preamble_detected(short_preamble_detected),
        .long_preamble_detected(long_preamble_detected),
        .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid(pkt_header_valid), .ht_unsupport(ht_unsupport),
        .phy_len_valid(phy_len_valid), .n_ofdm_sym(n_ofdm_sym),
        .ofdm_symbol_eq_out_pulse(ofdm_symbol_eq_out_pulse),
        .fcs_out_strobe(fcs_out_strobe),
        .long_timeout(long_timeout), .sig_timeout(sig_timeout),
        .sym_margin(sym_margin),
        .receiver_rst(receiver_rst), .timeout_cause(timeout_cause),
        .pkt_done(pkt_done), .timeout_cnt(timeout_cnt), .state(state)
    );

    rx_pkt_timeout_ctrl #(.STAT_WIDTH(3)) u_sat (
        .clock(clock), .reset(reset), .enable(enable),
        .sample_in_strobe(sample_in_strobe),
        .short_preamble_detected(short_preamble_detected),
        .long_preamble_detected(long_preamble_detected),
        .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid(pkt_header_valid), .ht_unsupport(ht_unsupport),
        .phy_len_valid(phy_len_valid), .n_ofdm_sym(n_ofdm_sym),
        .ofdm_symbol_eq_out_pulse(ofdm_symbol_eq_out_pulse),
        .fcs_out_strobe(fcs_out_strobe),
        .long_timeout(long_timeout), .sig_timeout(sig_timeout),
        .sym_margin(sym_margin),
        .receiver_rst(s_rst), .timeout_cause(s_cause),
        .pkt_done(s_done), .timeout_cnt(s_cnt), .state(s_state)
    );

    // Sticky record of any reset request, sampled away from the active edge.
    always @(negedge clock) if (receiver_rst) rst_seen <= 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called right after the edge that should enter RST.
    task automatic expect_rst(input string tag, input int cause, input int cnt);
        int n;
        chk({tag, "_state"}, 32'(state), 4);
        chk({tag, "_rst"},   32'(receiver_rst), 1);
        chk({tag, "_cause"}, 32'(timeout_cause), cause);
        chk({tag, "_cnt"},   32'(timeout_cnt), cnt);
        n = 1;
        repeat (8) begin
            tick();
            if (receiver_rst) n++;
        end
        chk({tag, "_pulse_len"}, 32'(n), 4);
        chk({tag, "_back_idle"}, 32'(state), 0);
        chk({tag, "_cause_hold"}, 32'(timeout_cause), cause);
    endtask

    task automatic to_wait_sig();
        short_preamble_detected = 1; tick(); short_preamble_detected = 0;
        long_preamble_detected  = 1; tick(); long_preamble_detected  = 0;
    endtask

    task automatic to_data();
        to_wait_sig();
        pkt_header_valid_strobe = 1; pkt_header_valid = 1; ht_unsupport = 0;
        tick();
        pkt_header_valid_strobe = 0;
        chk("enter_data", 32'(state), 3);
    endtask

    initial begin
        reset = 1; enable = 1; sample_in_strobe = 0;
        short_preamble_detected = 0; long_preamble_detected = 0;
        pkt_header_valid_strobe = 0; pkt_header_valid = 0; ht_unsupport = 0;
        phy_len_valid = 0; n_ofdm_sym = 15'd10; ofdm_symbol_eq_out_pulse = 0;
        fcs_out_strobe = 0; long_timeout = 16'd320; sig_timeout = 16'd200;
        sym_margin = 4'd2;
        tick(); tick();
        reset = 0;
        chk("reset_state", 32'(state), 0);
        chk("reset_rst",   32'(receiver_rst), 0);
        chk("reset_cause", 32'(timeout_cause), 0);
        chk("reset_done",  32'(pkt_done), 0);
        chk("reset_cnt",   32'(timeout_cnt), 0);

        // Normal packet: 10 symbols 80 samples apart, then FCS.
        rst_seen = 0;
        to_data();
        phy_len_valid = 1; tick(); phy_len_valid = 0;
        sample_in_strobe = 1;
        for (int i = 0; i < 10; i++) begin
            ofdm_symbol_eq_out_pulse = 1; tick(); ofdm_symbol_eq_out_pulse = 0;
            repeat (79) tick();
        end
        chk("norm_in_data", 32'(state), 3);
        fcs_out_strobe = 1; tick(); fcs_out_strobe = 0; sample_in_strobe = 0;
        chk("norm_done",  32'(pkt_done), 1);
        chk("norm_idle",  32'(state), 0);
        tick();
        chk("norm_done_1cyc", 32'(pkt_done), 0);
        chk("norm_no_rst", 32'(rst_seen), 0);
        chk("norm_cnt",   32'(timeout_cnt), 0);

        // Long-preamble timeout fires on the 320th strobe.
        short_preamble_detected = 1; tick(); short_preamble_detected = 0;
        sample_in_strobe = 1;
        repeat (319) tick();
        chk("long_319", 32'(state), 1);
        tick(); sample_in_strobe = 0;
        expect_rst("long_to", 1, 1);

        // Bad header, then unsupported HT header.
        to_wait_sig();
        short_preamble_detected = 1; tick(); short_preamble_detected = 0;
        chk("short_ignored", 32'(state), 2);
        pkt_header_valid_strobe = 1; pkt_header_valid = 0; tick();
        pkt_header_valid_strobe = 0;
        expect_rst("hdr_bad", 3, 2);
        to_wait_sig();
        pkt_header_valid_strobe = 1; pkt_header_valid = 1; ht_unsupport = 1; tick();
        pkt_header_valid_strobe = 0; ht_unsupport = 0;
        expect_rst("hdr_ht", 3, 3);

        // Symbol overrun: limit 12, 13th symbol resets.
        to_data();
        phy_len_valid = 1; tick(); phy_len_valid = 0;
        for (int i = 0; i < 12; i++) begin
            ofdm_symbol_eq_out_pulse = 1; tick(); ofdm_symbol_eq_out_pulse = 0; tick();
        end
        chk("ovr_12_ok", 32'(state), 3);
        ofdm_symbol_eq_out_pulse = 1; tick(); ofdm_symbol_eq_out_pulse = 0;
        expect_rst("sym_ovr", 4, 4);

        // 12 symbols, then a 13th coinciding with FCS: completion wins.
        rst_seen = 0;
        to_data();
        phy_len_valid = 1; tick(); phy_len_valid = 0;
        for (int i = 0; i < 12; i++) begin
            ofdm_symbol_eq_out_pulse = 1; tick(); ofdm_symbol_eq_out_pulse = 0; tick();
        end
        ofdm_symbol_eq_out_pulse = 1; fcs_out_strobe = 1; tick();
        ofdm_symbol_eq_out_pulse = 0; fcs_out_strobe = 0;
        chk("fcs_win_done", 32'(pkt_done), 1);
        chk("fcs_win_idle", 32'(state), 0);
        tick();
        chk("fcs_win_norst", 32'(rst_seen), 0);

        // Symbol gap: 200 strobes without a symbol.
        to_data();
        sample_in_strobe = 1;
        repeat (199) tick();
        chk("gap_199", 32'(state), 3);
        tick(); sample_in_strobe = 0;
        expect_rst("sym_gap", 5, 5);

        // Progress beats timeout in WAIT_LONG; bad header beats sig timeout.
        short_preamble_detected = 1; tick(); short_preamble_detected = 0;
        sample_in_strobe = 1;
        repeat (319) tick();
        long_preamble_detected = 1; tick(); long_preamble_detected = 0;
        chk("prog_win", 32'(state), 2);
        repeat (199) tick();
        pkt_header_valid_strobe = 1; pkt_header_valid = 0; tick();
        pkt_header_valid_strobe = 0; sample_in_strobe = 0;
        expect_rst("hdr_vs_sig", 3, 6);

        // Disabled sig timeout: timer saturates, no reset.
        rst_seen = 0;
        to_data();
        sig_timeout = 16'd0; sample_in_strobe = 1;
        repeat (65600) tick();
        chk("t0_in_data", 32'(state), 3);
        chk("t0_norst", 32'(rst_seen), 0);
        sig_timeout = 16'd200;
        tick();
        chk("t0_sat_nofire", 32'(state), 3);
        sample_in_strobe = 0;
        fcs_out_strobe = 1; tick(); fcs_out_strobe = 0;
        chk("t0_done", 32'(pkt_done), 1);

        // Enable drop in WAIT_SIG.
        rst_seen = 0;
        to_wait_sig();
        enable = 0; tick();
        chk("en_idle", 32'(state), 0);
        tick();
        chk("en_norst", 32'(rst_seen), 0);
        chk("en_cnt", 32'(timeout_cnt), 6);
        enable = 1;

        // Enable drop during RST does not shorten the pulse.
        long_timeout = 16'd1;
        short_preamble_detected = 1; tick(); short_preamble_detected = 0;
        sample_in_strobe = 1; tick(); sample_in_strobe = 0;
        enable = 0;
        expect_rst("en_in_rst", 1, 7);
        enable = 1;
        chk("sat_7", 32'(s_cnt), 7);

        // One more timeout: narrow counter holds at max.
        short_preamble_detected = 1; tick(); short_preamble_detected = 0;
        sample_in_strobe = 1; tick(); sample_in_strobe = 0;
        expect_rst("long_1", 1, 8);
        chk("sat_hold", 32'(s_cnt), 7);

        // Reset mid-pulse.
        short_preamble_detected = 1; tick(); short_preamble_detected = 0;
        sample_in_strobe = 1; tick(); sample_in_strobe = 0;
        chk("mid_entry", 32'(receiver_rst), 1);
        tick();
        chk("mid_still", 32'(receiver_rst), 1);
        reset = 1; tick(); reset = 0;
        chk("mid_rst_drop", 32'(receiver_rst), 0);
        chk("mid_state", 32'(state), 0);
        chk("mid_cnt", 32'(timeout_cnt), 0);
        chk("mid_cause", 32'(timeout_cause), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
